// File: rtl/leaf_out_arbiter.sv
// Round-robin scheduler for a leaf's single outbound BFT packet channel.
// Grants one user output stream per cycle under per-stream credit flow control.
module leaf_out_arbiter #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int NUM_OUT_PORTS = 4
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
  input  logic                                    cfg_wr,
  input  logic [NUM_PORT_BITS-1:0]                cfg_port,
  input  logic [NUM_LEAF_BITS+NUM_PORT_BITS-1:0]  cfg_dest,
  input  logic                                    credit_vld,
  input  logic [NUM_PORT_BITS-1:0]                credit_port,
  input  logic [NUM_ADDR_BITS:0]                  credit_amount,
  input  logic                                    bft_ready,
  output logic [PACKET_BITS-1:0]                  dout_leaf_interface2bft
);

  localparam int DEST_W = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int CRED_W = NUM_ADDR_BITS + 1;
  localparam int PTR_W  = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(2**NUM_ADDR_BITS);

  function automatic logic [CRED_W-1:0] sat_credit(input logic [CRED_W:0] sum);
    if (sum > {1'b0, CRED_MAX}) return CRED_MAX;
    return sum[CRED_W-1:0];
  endfunction

  // Stream index (base + k) mod NUM_OUT_PORTS without relying on a power-of-two count.
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int k);
    int j;
    j = int'(base) + k;
    if (j >= NUM_OUT_PORTS) j = j - NUM_OUT_PORTS;
    return PTR_W'(j);
  endfunction

  logic [NUM_OUT_PORTS-1:0] cfg_ok;
  logic [DEST_W-1:0]        dest      [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr      [NUM_OUT_PORTS];
  logic [CRED_W-1:0]        credit    [NUM_OUT_PORTS];
  logic [CRED_W-1:0]        credit_nxt[NUM_OUT_PORTS];
  logic [PTR_W-1:0]         rr_ptr;

  logic [PACKET_BITS-1:0]   pkt_p0;
  logic [PACKET_BITS-1:0]   pkt_p1;
  logic                     vld_p1;

  logic [NUM_OUT_PORTS-1:0] eligible;
  logic [NUM_OUT_PORTS-1:0] xfer;
  logic                     slot_free;
  logic                     gnt_found;
  logic [PTR_W-1:0]         gnt_idx;
  logic                     grant_en;

  assign vld_p1    = pkt_p1[PACKET_BITS-1];
  assign slot_free = ~vld_p1 | bft_ready;
  assign grant_en  = slot_free & gnt_found;

  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      eligible[i] = vld_user2interface[i] & cfg_ok[i] & (credit[i] != '0);
    end
  end

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_OUT_PORTS; k++) begin
      if (!gnt_found && eligible[wrap_idx(rr_ptr, k)]) begin
        gnt_found = 1'b1;
        gnt_idx   = wrap_idx(rr_ptr, k);
      end
    end
  end

  always_comb begin
    ack_interface2user = '0;
    if (grant_en) ack_interface2user[gnt_idx] = 1'b1;
  end

  assign xfer = ack_interface2user & vld_user2interface;

  // Stage p0: packet assembled from the granted stream's current table entry.
  always_comb begin
    pkt_p0 = '0;
    if (grant_en) begin
      pkt_p0 = {1'b1, dest[gnt_idx], addr[gnt_idx],
                din_leaf_user2interface[gnt_idx*PAYLOAD_BITS +: PAYLOAD_BITS]};
    end
  end

  // A same-cycle send and credit return net out before saturating.
  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      credit_nxt[i] = sat_credit({1'b0, credit[i]} - (CRED_W+1)'(xfer[i])
                                 + ((credit_vld && credit_port == NUM_PORT_BITS'(i))
                                    ? {1'b0, credit_amount} : '0));
    end
  end

  // Stage p1: packet register and per-stream bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_p1 <= '0;
      rr_ptr <= '0;
      cfg_ok <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        dest[i]   <= '0;
        addr[i]   <= '0;
        credit[i] <= CRED_MAX;
      end
    end else begin
      if (slot_free) pkt_p1 <= pkt_p0;
      if (grant_en)  rr_ptr <= wrap_idx(gnt_idx, 1);
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit[i] <= credit_nxt[i];
        if (xfer[i]) addr[i] <= addr[i] + 1'b1;
        if (cfg_wr && cfg_port == NUM_PORT_BITS'(i)) begin
          dest[i]   <= cfg_dest;
          cfg_ok[i] <= 1'b1;
        end
      end
    end
  end

  assign dout_leaf_interface2bft = pkt_p1;

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Directed bench for leaf_out_arbiter: table-driven round-robin/backpressure
// vectors followed by hand-written credit, configuration and reset sequences.
module tb_leaf_out_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] din;
  logic [3:0]   vld;
  logic [3:0]   ack;
  logic         cfg_wr;
  logic [3:0]   cfg_port;
  logic [8:0]   cfg_dest;
  logic         credit_vld;
  logic [3:0]   credit_port;
  logic [7:0]   credit_amount;
  logic         rdy;
  logic [48:0]  dout;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]  vld;
    logic        rdy;
    logic [3:0]  ack;
    logic [48:0] pkt;
  } vec_t;

  vec_t        tv [22];
  logic [31:0] pl [4];
  logic [4:0]  exp_leaf;
  logic [3:0]  exp_port;

  leaf_out_arbiter dut (
    .clk                     (clk),
    .reset                   (reset),
    .din_leaf_user2interface (din),
    .vld_user2interface      (vld),
    .ack_interface2user      (ack),
    .cfg_wr                  (cfg_wr),
    .cfg_port                (cfg_port),
    .cfg_dest                (cfg_dest),
    .credit_vld              (credit_vld),
    .credit_port             (credit_port),
    .credit_amount           (credit_amount),
    .bft_ready               (rdy),
    .dout_leaf_interface2bft (dout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [48:0] mk(input logic [4:0] l, input logic [3:0] p,
                                     input logic [6:0] a, input logic [31:0] d);
    return {1'b1, l, p, a, d};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Called #1 after a rising edge with inputs already set for this cycle.
  task automatic xfer_cycle(input string nm, input logic [3:0] exp_ack, input logic [48:0] exp_pkt);
    #1;
    chk({nm, "_ack"}, 64'(ack), 64'(exp_ack));
    @(posedge clk);
    #1;
    chk({nm, "_pkt"}, 64'(dout), 64'(exp_pkt));
  endtask

  initial begin
    pl[0] = 32'hAAAA_0000;
    pl[1] = 32'hBBBB_0001;
    pl[2] = 32'hCCCC_0002;
    pl[3] = 32'hDDDD_0003;
    din   = {pl[3], pl[2], pl[1], pl[0]};

    for (int k = 0; k < 8; k++) begin
      tv[k] = '{4'hF, 1'b1, 4'(1 << (k % 4)), mk(5'd3, 4'(k % 4 + 1), 7'(k / 4), pl[k % 4])};
    end
    tv[8]  = '{4'b1010, 1'b1, 4'b0010, mk(5'd3, 4'd2, 7'd2, pl[1])};
    tv[9]  = '{4'b1010, 1'b1, 4'b1000, mk(5'd3, 4'd4, 7'd2, pl[3])};
    tv[10] = '{4'b0001, 1'b1, 4'b0001, mk(5'd3, 4'd1, 7'd2, pl[0])};
    tv[11] = '{4'b0000, 1'b1, 4'b0000, 49'd0};
    tv[12] = '{4'b0101, 1'b1, 4'b0100, mk(5'd3, 4'd3, 7'd2, pl[2])};
    tv[13] = '{4'b0001, 1'b1, 4'b0001, mk(5'd3, 4'd1, 7'd3, pl[0])};
    tv[14] = '{4'b1111, 1'b0, 4'b0000, mk(5'd3, 4'd1, 7'd3, pl[0])};
    tv[15] = '{4'b1111, 1'b0, 4'b0000, mk(5'd3, 4'd1, 7'd3, pl[0])};
    tv[16] = '{4'b1111, 1'b0, 4'b0000, mk(5'd3, 4'd1, 7'd3, pl[0])};
    tv[17] = '{4'b1111, 1'b1, 4'b0010, mk(5'd3, 4'd2, 7'd3, pl[1])};
    tv[18] = '{4'b0000, 1'b0, 4'b0000, mk(5'd3, 4'd2, 7'd3, pl[1])};
    tv[19] = '{4'b0000, 1'b1, 4'b0000, 49'd0};
    tv[20] = '{4'b1111, 1'b0, 4'b0100, mk(5'd3, 4'd3, 7'd3, pl[2])};
    tv[21] = '{4'b1111, 1'b0, 4'b0000, mk(5'd3, 4'd3, 7'd3, pl[2])};

    reset = 1'b1; vld = 4'h0; rdy = 1'b1;
    cfg_wr = 1'b0; cfg_port = '0; cfg_dest = '0;
    credit_vld = 1'b0; credit_port = '0; credit_amount = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_pkt", 64'(dout), 64'd0);
    chk("reset_ack", 64'(ack), 64'd0);
    reset = 1'b0;

    vld = 4'hF;
    for (int k = 0; k < 10; k++) xfer_cycle("idle_nocfg", 4'h0, 49'd0);

    vld = 4'h0;
    for (int i = 0; i < 4; i++) begin
      cfg_wr = 1'b1; cfg_port = 4'(i); cfg_dest = {5'd3, 4'(i + 1)};
      xfer_cycle("cfg", 4'h0, 49'd0);
    end
    cfg_wr = 1'b0;

    for (int s = 0; s < 22; s++) begin
      vld = tv[s].vld;
      rdy = tv[s].rdy;
      xfer_cycle($sformatf("vec%0d", s), tv[s].ack, tv[s].pkt);
    end

    // Reset in the middle of a burst.
    vld = 4'hF; rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_pkt", 64'(dout), 64'd0);
    chk("mrst_ack", 64'(ack), 64'd0);
    reset = 1'b0;
    xfer_cycle("mrst_cfgclr", 4'h0, 49'd0);

    vld = 4'h0;
    cfg_wr = 1'b1; cfg_port = 4'd2; cfg_dest = {5'd7, 4'd9};
    xfer_cycle("cfg2", 4'h0, 49'd0);
    cfg_wr = 1'b0;

    // Stream 2 alone drains its full credit; includes an ignored and a live cfg write.
    vld = 4'b0100;
    exp_leaf = 5'd7; exp_port = 4'd9;
    for (int k = 0; k < 128; k++) begin
      if (k == 5)  begin cfg_wr = 1'b1; cfg_port = 4'd6; cfg_dest = 9'h1FF; end
      if (k == 10) begin cfg_wr = 1'b1; cfg_port = 4'd2; cfg_dest = {5'd12, 4'd5}; end
      xfer_cycle("exhaust", 4'b0100, mk(exp_leaf, exp_port, 7'(k), pl[2]));
      cfg_wr = 1'b0;
      if (k == 10) begin exp_leaf = 5'd12; exp_port = 4'd5; end
    end
    for (int k = 0; k < 3; k++) xfer_cycle("no_credit", 4'h0, 49'd0);

    credit_vld = 1'b1; credit_port = 4'd10; credit_amount = 8'd64;
    xfer_cycle("oor_credit10", 4'h0, 49'd0);
    credit_port = 4'd9;
    xfer_cycle("oor_credit9", 4'h0, 49'd0);
    credit_vld = 1'b0;
    xfer_cycle("oor_ignored", 4'h0, 49'd0);

    credit_vld = 1'b1; credit_port = 4'd2; credit_amount = 8'd64;
    xfer_cycle("credit_ret", 4'h0, 49'd0);
    credit_vld = 1'b0;
    for (int k = 0; k < 64; k++) begin
      xfer_cycle("refill", 4'b0100, mk(5'd12, 4'd5, 7'(k), pl[2]));
    end
    for (int k = 0; k < 2; k++) xfer_cycle("refill_done", 4'h0, 49'd0);

    // Stream 1: send and return in one cycle at full credit, then an over-return.
    vld = 4'h0;
    cfg_wr = 1'b1; cfg_port = 4'd1; cfg_dest = {5'd1, 4'd2};
    xfer_cycle("cfg1", 4'h0, 49'd0);
    cfg_wr = 1'b0;

    vld = 4'b0010;
    credit_vld = 1'b1; credit_port = 4'd1; credit_amount = 8'd1;
    xfer_cycle("simul", 4'b0010, mk(5'd1, 4'd2, 7'd0, pl[1]));
    vld = 4'h0; credit_amount = 8'd5;
    xfer_cycle("sat_ret", 4'h0, 49'd0);
    credit_vld = 1'b0;
    vld = 4'b0010;
    for (int k = 0; k < 128; k++) begin
      xfer_cycle("sat_drain", 4'b0010, mk(5'd1, 4'd2, 7'(k + 1), pl[1]));
    end
    xfer_cycle("sat_empty", 4'h0, 49'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/leaf_out_arbiter.md
# leaf_out_arbiter

Round-robin scheduler that shares a leaf page's single outbound BFT packet channel among the user core's output streams. It grants one valid/ack user stream per cycle and builds a 49-bit BFT packet from the stream's configured destination leaf/port, a per-stream BRAM write address and the payload. It enforces per-stream credit-based flow control against the destination's free space. It sits between the user kernel's output streams and the leaf's bft-facing packet port.

## Interface
- PACKET_BITS, 49, packet width = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS
- PAYLOAD_BITS, 32, user data width
- NUM_LEAF_BITS, 5, destination leaf field width
- NUM_PORT_BITS, 4, destination port field width
- NUM_ADDR_BITS, 7, destination BRAM address width; credit ceiling is 2^NUM_ADDR_BITS
- NUM_OUT_PORTS, 4, number of user output streams (≤ 2^NUM_PORT_BITS)
- clk  in  1  single clock
- reset  in  1  synchronous, active-high reset
- din_leaf_user2interface  in  NUM_OUT_PORTS*PAYLOAD_BITS  stream payloads; stream i occupies slice [i*PAYLOAD_BITS +: PAYLOAD_BITS]
- vld_user2interface  in  NUM_OUT_PORTS  per-stream valid
- ack_interface2user  out  NUM_OUT_PORTS  per-stream ack (ready); one-hot or zero
- cfg_wr  in  1  destination table write strobe
- cfg_port  in  NUM_PORT_BITS  stream index to configure
- cfg_dest  in  NUM_LEAF_BITS+NUM_PORT_BITS  {dest_leaf, dest_port}
- credit_vld  in  1  credit return strobe
- credit_port  in  NUM_PORT_BITS  stream receiving credit
- credit_amount  in  NUM_ADDR_BITS+1  credits returned
- bft_ready  in  1  downstream accepts the packet register this cycle
- dout_leaf_interface2bft  out  PACKET_BITS  {valid, dest_leaf, dest_port, addr, payload}

## Operation
- Per-stream state: cfg_ok bit, dest {leaf, port}, addr counter (NUM_ADDR_BITS), credit counter (NUM_ADDR_BITS+1 bits).
- Reset values:
  - cfg_ok = 0, dest = 0, addr = 0, credit = 2^NUM_ADDR_BITS.
  - RR pointer = 0; stream 0 has highest priority.
  - Packet register = all zeros (valid bit 0).
  - ack_interface2user = 0.
- Slot free: the packet register has valid = 0, or bft_ready = 1.
- Eligible stream i: vld_user2interface[i] & cfg_ok[i] & credit[i] != 0.
- Grant: when the slot is free, pick the first eligible stream searching from the RR pointer upward, with wrap-around. Drive ack[i] = 1 for that stream only.
- On transfer of stream i (vld & ack):
  - Packet register loads {1, dest_leaf[i], dest_port[i], addr[i], payload_i}.
  - addr[i] increments modulo 2^NUM_ADDR_BITS (127 → 0).
  - credit[i] decrements.
  - RR pointer becomes (i+1) mod NUM_OUT_PORTS.
- If the slot is free but nothing is eligible, the register loads all zeros and the RR pointer holds.
- If the slot is not free (valid = 1, bft_ready = 0), the register holds its contents and all acks are 0.
- Configuration: cfg_wr sets dest[cfg_port] and cfg_ok = 1. A write with cfg_port ≥ NUM_OUT_PORTS is ignored. A same-cycle grant uses the old dest; the new dest applies from the next cycle. Writes do not reset addr or credit.
- Credit: credit_vld adds credit_amount to credit[credit_port].
  - Out-of-range credit_port is ignored.
  - When a credit return and a transfer hit the same stream in the same cycle, the result is credit − 1 + amount.
  - The result saturates at 2^NUM_ADDR_BITS.
- Reset mid-operation: any pending packet is discarded and all state returns to reset values on the next edge.

## Timing
- ack is combinational from vld, cfg_ok, credit, packet valid and bft_ready in the same cycle. It does not depend on any other ack.
- Transfer at edge N: the packet is visible on dout_leaf_interface2bft after edge N, with 1-cycle latency.
- Sustained throughput is 1 packet per cycle while bft_ready = 1 and some stream is eligible.
- Credit and cfg updates are visible to eligibility one cycle after their edge.
- The packet register holds stable, with no change, while valid = 1 and bft_ready = 0.

## Test plan
- **Reset/idle:** hold reset 2 cycles, then vld = 4'b1111 with no cfg → acks = 0, dout = 0 for 10 cycles.
- **Round-robin:** configure streams 0–3 to leaf 3 ports 1–4 and keep vld = 4'b1111 with bft_ready = 1 → grants follow 0,1,2,3,0,… Stream 0's first packet is {1, 5'd3, 4'd1, 7'd0, payload}. Addr increments per stream.
- **Backpressure:** with a packet pending, drop bft_ready for 3 cycles → dout is unchanged and acks are 0. Raise bft_ready → the next grant goes to the stream after the last one granted.
- **Credit exhaustion:** stream 2 only, 128 transfers → credit reaches 0 and ack[2] stays low. Return credit_amount = 64 → 64 more transfers complete; the addr wraps 127 → 0 at transfer 129.
- **Simultaneous credit/send:** with credit[1] = 128, transfer on stream 1 and return 1 credit in the same cycle → credit stays 128 (saturation). Out-of-range credit_port = 9 has no effect.
- **Mid-stream reset:** assert reset during burst traffic → next cycle dout = 0, acks = 0, cfg_ok cleared, credits = 128, addr = 0.
